dcache_read_ctrl: RTL and testbench

- Per-port read controller of the write-through L1 data cache; one instance each serves the load unit and the PTW.
- Accepts index-first load requests from the core and issues tag/data reads to the cache memory arbiter.
- Performs the hit check once the physical tag arrives late, forwards misses to the miss unit, and replays reads on refill collisions.
- Supports request kill and the non-cacheable (cache disabled) path.

---
 rtl/dcache_read_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dcache_read_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_read_ctrl.sv
// Read controller for one port of the write-through L1 data cache: issues tag/data
// reads, resolves hits against the late physical tag, and hands misses to the miss unit.
module dcache_read_ctrl #(
    parameter int unsigned TAG_W    = 44,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned OFF_W    = 4,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned RD_TX_ID = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cache_en_i,
    input  logic                         stall_i,
    output logic                         busy_o,

    input  logic                         req_valid_i,
    input  logic [IDX_W-1:0]             req_idx_i,
    input  logic [OFF_W-1:0]             req_off_i,
    input  logic [1:0]                   req_size_i,
    output logic                         req_gnt_o,
    input  logic                         tag_valid_i,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic                         kill_req_i,
    output logic                         rvalid_o,
    output logic [XLEN-1:0]              rdata_o,

    output logic                         miss_req_o,
    input  logic                         miss_ack_i,
    output logic                         miss_nc_o,
    output logic [TAG_W+IDX_W+OFF_W-1:0] miss_paddr_o,
    output logic [2:0]                   miss_size_o,
    output logic [ID_W-1:0]              miss_id_o,
    output logic [WAYS-1:0]              miss_vld_bits_o,
    input  logic                         miss_replay_i,
    input  logic                         miss_rtrn_vld_i,
    input  logic [XLEN-1:0]              miss_rtrn_data_i,

    input  logic                         wr_cl_vld_i,
    output logic                         rd_req_o,
    input  logic                         rd_ack_i,
    output logic [TAG_W-1:0]             rd_tag_o,
    output logic [IDX_W-1:0]             rd_idx_o,
    output logic [OFF_W-1:0]             rd_off_o,
    output logic                         rd_tag_only_o,
    input  logic [XLEN-1:0]              rd_data_i,
    input  logic [WAYS-1:0]              rd_vld_bits_i,
    input  logic [WAYS-1:0]              rd_hit_oh_i
);

    typedef enum logic [2:0] {
        IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, REPLAY_REQ, REPLAY_READ
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic [TAG_W-1:0] tag_q;
    logic             tag_captured_q;
    logic             cache_en_q;
    logic [WAYS-1:0]  vld_bits_q;

    logic hit;
    logic tag_avail;
    logic use_req_addr;
    logic capture_tag;
    logic latch_vld;

    // A disabled cache never hits, so every access takes the non-cacheable miss path
    assign hit       = (|rd_hit_oh_i) & cache_en_q;
    assign tag_avail = tag_valid_i | tag_captured_q;

    always_comb begin
        state_d         = state_q;
        rd_req_o        = 1'b0;
        req_gnt_o       = 1'b0;
        rvalid_o        = 1'b0;
        rdata_o         = '0;
        miss_req_o      = 1'b0;
        miss_nc_o       = 1'b0;
        miss_size_o     = 3'b000;
        miss_id_o       = '0;
        miss_paddr_o    = '0;
        miss_vld_bits_o = '0;
        use_req_addr    = 1'b0;
        capture_tag     = 1'b0;
        latch_vld       = 1'b0;

        case (state_q)
            IDLE: begin
                use_req_addr = 1'b1;
                if (req_valid_i && !stall_i) begin
                    rd_req_o = 1'b1;
                    if (rd_ack_i) begin
                        req_gnt_o = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            READ, REPLAY_READ: begin
                if (kill_req_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (!tag_avail) begin
                    state_d = REPLAY_REQ;
                end else begin
                    capture_tag = !tag_captured_q;
                    if (wr_cl_vld_i) begin
                        state_d = REPLAY_REQ;
                    end else if (hit) begin
                        rvalid_o = 1'b1;
                        rdata_o  = rd_data_i;
                        state_d  = IDLE;
                        // A hit frees the pipeline, so the next request can be issued in the same cycle
                        if (req_valid_i && !stall_i) begin
                            use_req_addr = 1'b1;
                            rd_req_o     = 1'b1;
                            if (rd_ack_i) begin
                                req_gnt_o = 1'b1;
                                state_d   = READ;
                            end
                        end
                    end else begin
                        latch_vld = 1'b1;
                        state_d   = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                miss_req_o      = 1'b1;
                miss_paddr_o    = {tag_q, idx_q, off_q};
                miss_nc_o       = ~cache_en_q;
                miss_size_o     = cache_en_q ? 3'b111 : {1'b0, size_q};
                miss_id_o       = ID_W'(RD_TX_ID);
                miss_vld_bits_o = vld_bits_q;
                if (kill_req_i) begin
                    rvalid_o = 1'b1;
                    state_d  = miss_ack_i ? KILL_MISS : IDLE;
                end else if (miss_replay_i) begin
                    state_d = REPLAY_REQ;
                end else if (miss_ack_i) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (miss_rtrn_vld_i) begin
                    rvalid_o = 1'b1;
                    rdata_o  = miss_rtrn_data_i;
                    state_d  = IDLE;
                end else if (kill_req_i) begin
                    rvalid_o = 1'b1;
                    state_d  = KILL_MISS;
                end
            end
            KILL_MISS: begin
                if (miss_rtrn_vld_i) begin
                    state_d = IDLE;
                end
            end
            REPLAY_REQ: begin
                rd_req_o = 1'b1;
                if (kill_req_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (rd_ack_i) begin
                    state_d = REPLAY_READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh grant always wins over tag capture so the new request starts without a tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            off_q          <= '0;
            size_q         <= '0;
            tag_q          <= '0;
            tag_captured_q <= 1'b0;
            cache_en_q     <= 1'b0;
            vld_bits_q     <= '0;
        end else begin
            state_q <= state_d;
            if (req_gnt_o) begin
                idx_q          <= req_idx_i;
                off_q          <= req_off_i;
                size_q         <= req_size_i;
                cache_en_q     <= cache_en_i;
                tag_captured_q <= 1'b0;
            end else if (capture_tag) begin
                tag_q          <= tag_i;
                tag_captured_q <= 1'b1;
            end
            if (latch_vld) begin
                vld_bits_q <= rd_vld_bits_i;
            end
        end
    end

    assign rd_idx_o      = use_req_addr ? req_idx_i : idx_q;
    assign rd_off_o      = use_req_addr ? req_off_i : off_q;
    assign rd_tag_o      = tag_captured_q ? tag_q : tag_i;
    assign rd_tag_only_o = 1'b0;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_read_ctrl.sv
// Directed bench for dcache_read_ctrl: hit, miss, non-cacheable, collision replay,
// kill during miss wait, back-to-back hits and stall.
module tb_dcache_read_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cache_en_i, stall_i, busy_o;
    logic        req_valid_i;
    logic [7:0]  req_idx_i;
    logic [3:0]  req_off_i;
    logic [1:0]  req_size_i;
    logic        req_gnt_o, tag_valid_i, kill_req_i, rvalid_o;
    logic [43:0] tag_i;
    logic [63:0] rdata_o;
    logic        miss_req_o, miss_ack_i, miss_nc_o, miss_replay_i, miss_rtrn_vld_i;
    logic [55:0] miss_paddr_o;
    logic [2:0]  miss_size_o;
    logic [1:0]  miss_id_o;
    logic [3:0]  miss_vld_bits_o;
    logic [63:0] miss_rtrn_data_i;
    logic        wr_cl_vld_i, rd_req_o, rd_ack_i, rd_tag_only_o;
    logic [43:0] rd_tag_o;
    logic [7:0]  rd_idx_o;
    logic [3:0]  rd_off_o;
    logic [63:0] rd_data_i;
    logic [3:0]  rd_vld_bits_i, rd_hit_oh_i;

    int total = 0;
    int bad   = 0;

    dcache_read_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cache_en_i(cache_en_i), .stall_i(stall_i), .busy_o(busy_o),
        .req_valid_i(req_valid_i), .req_idx_i(req_idx_i), .req_off_i(req_off_i),
        .req_size_i(req_size_i), .req_gnt_o(req_gnt_o), .tag_valid_i(tag_valid_i),
        .tag_i(tag_i), .kill_req_i(kill_req_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_nc_o(miss_nc_o),
        .miss_paddr_o(miss_paddr_o), .miss_size_o(miss_size_o), .miss_id_o(miss_id_o),
        .miss_vld_bits_o(miss_vld_bits_o), .miss_replay_i(miss_replay_i),
        .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_rtrn_data_i(miss_rtrn_data_i),
        .wr_cl_vld_i(wr_cl_vld_i), .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i),
        .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
        .rd_tag_only_o(rd_tag_only_o), .rd_data_i(rd_data_i),
        .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i)
    );

    always #5 clk_i = ~clk_i;

    // Return every request-side input to its quiet value; cache enable is left alone
    task automatic clear_inputs();
        stall_i = 0; req_valid_i = 0; req_idx_i = 0; req_off_i = 0; req_size_i = 0;
        tag_valid_i = 0; tag_i = 0; kill_req_i = 0; miss_ack_i = 0; miss_replay_i = 0;
        miss_rtrn_vld_i = 0; miss_rtrn_data_i = 0; wr_cl_vld_i = 0; rd_ack_i = 0;
        rd_data_i = 0; rd_vld_bits_i = 0; rd_hit_oh_i = 0;
    endtask

    // Drive a request with an immediate arbiter grant on the next falling edge
    task automatic issue_req(input logic [7:0] idx, input logic [3:0] off,
                             input logic [1:0] size, input logic en);
        @(negedge clk_i);
        clear_inputs();
        cache_en_i = en; req_valid_i = 1; req_idx_i = idx; req_off_i = off;
        req_size_i = size; rd_ack_i = 1;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1; cache_en_i = 0; clear_inputs();
        req_valid_i = 1; rd_ack_i = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid_o); end
        total++; if (miss_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_miss_req: got %b want 0", miss_req_o); end
        total++; if (rd_tag_only_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tag_only: got %b want 0", rd_tag_only_o); end
        clear_inputs();
        rst_i = 0;
    endtask

    task automatic test_hit();
        issue_req(8'h12, 4'h8, 2'd3, 1'b1);
        total++; if (req_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL hit_gnt: got %b want 1", req_gnt_o); end
        total++; if (rd_req_o !== 1'b1) begin bad++; $display("[TB] FAIL hit_rd_req: got %b want 1", rd_req_o); end
        total++; if (rd_idx_o !== 8'h12) begin bad++; $display("[TB] FAIL hit_rd_idx: got %h want 12", rd_idx_o); end
        @(negedge clk_i);
        clear_inputs(); tag_valid_i = 1; tag_i = 44'hABC; rd_hit_oh_i = 4'b0100; rd_data_i = 64'hDEAD;
        #1;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL hit_rvalid: got %b want 1", rvalid_o); end
        total++; if (rdata_o !== 64'hDEAD) begin bad++; $display("[TB] FAIL hit_rdata: got %h want dead", rdata_o); end
        total++; if (rd_tag_o !== 44'hABC) begin bad++; $display("[TB] FAIL hit_rd_tag: got %h want abc", rd_tag_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL hit_idle: got busy=%b want 0", busy_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL hit_single_rvalid: got %b want 0", rvalid_o); end
    endtask

    task automatic test_miss();
        issue_req(8'h12, 4'h8, 2'd3, 1'b1);
        @(negedge clk_i);
        clear_inputs(); tag_valid_i = 1; tag_i = 44'hABC; rd_hit_oh_i = 4'b0000; rd_vld_bits_i = 4'b1011;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL miss_no_rvalid: got %b want 0", rvalid_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (miss_req_o !== 1'b1) begin bad++; $display("[TB] FAIL miss_req: got %b want 1", miss_req_o); end
        total++; if (miss_paddr_o !== {44'hABC, 8'h12, 4'h8}) begin bad++; $display("[TB] FAIL miss_paddr: got %h want %h", miss_paddr_o, {44'hABC, 8'h12, 4'h8}); end
        total++; if (miss_size_o !== 3'b111) begin bad++; $display("[TB] FAIL miss_size: got %b want 111", miss_size_o); end
        total++; if (miss_nc_o !== 1'b0) begin bad++; $display("[TB] FAIL miss_nc: got %b want 0", miss_nc_o); end
        total++; if (miss_vld_bits_o !== 4'b1011) begin bad++; $display("[TB] FAIL miss_vld_bits: got %b want 1011", miss_vld_bits_o); end
        total++; if (miss_id_o !== 2'd1) begin bad++; $display("[TB] FAIL miss_id: got %0d want 1", miss_id_o); end
        @(negedge clk_i); miss_ack_i = 1; #1;
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (miss_req_o !== 1'b0 || rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL miss_wait_quiet: got req=%b rvalid=%b want 0 0", miss_req_o, rvalid_o); end
        @(negedge clk_i); miss_rtrn_vld_i = 1; miss_rtrn_data_i = 64'h1234; #1;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL miss_rvalid: got %b want 1", rvalid_o); end
        total++; if (rdata_o !== 64'h1234) begin bad++; $display("[TB] FAIL miss_rdata: got %h want 1234", rdata_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL miss_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_noncacheable();
        issue_req(8'h34, 4'h4, 2'd2, 1'b0);
        @(negedge clk_i);
        clear_inputs(); cache_en_i = 1; tag_valid_i = 1; tag_i = 44'h777; rd_hit_oh_i = 4'b0001;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL nc_no_hit: got rvalid=%b want 0", rvalid_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (miss_nc_o !== 1'b1) begin bad++; $display("[TB] FAIL nc_flag: got %b want 1", miss_nc_o); end
        total++; if (miss_size_o !== 3'b010) begin bad++; $display("[TB] FAIL nc_size: got %b want 010", miss_size_o); end
        @(negedge clk_i); miss_ack_i = 1; #1;
        @(negedge clk_i); clear_inputs(); miss_rtrn_vld_i = 1; miss_rtrn_data_i = 64'h55AA; #1;
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 64'h55AA) begin bad++; $display("[TB] FAIL nc_return: got rvalid=%b data=%h want 1 55aa", rvalid_o, rdata_o); end
        @(negedge clk_i); clear_inputs(); #1;
    endtask

    task automatic test_collision();
        issue_req(8'h12, 4'h8, 2'd3, 1'b1);
        @(negedge clk_i);
        clear_inputs(); tag_valid_i = 1; tag_i = 44'hABC; rd_hit_oh_i = 4'b0100; rd_data_i = 64'h9999; wr_cl_vld_i = 1;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL coll_no_rvalid: got %b want 0", rvalid_o); end
        @(negedge clk_i); clear_inputs(); req_idx_i = 8'h55; req_off_i = 4'h1; #1;
        total++; if (rd_req_o !== 1'b1) begin bad++; $display("[TB] FAIL coll_reissue: got rd_req=%b want 1", rd_req_o); end
        total++; if (rd_idx_o !== 8'h12 || rd_off_o !== 4'h8) begin bad++; $display("[TB] FAIL coll_addr: got idx=%h off=%h want 12 8", rd_idx_o, rd_off_o); end
        total++; if (req_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL coll_no_gnt: got %b want 0", req_gnt_o); end
        @(negedge clk_i); rd_ack_i = 1; #1;
        @(negedge clk_i); clear_inputs(); rd_hit_oh_i = 4'b0100; rd_data_i = 64'hBEEF; #1;
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 64'hBEEF) begin bad++; $display("[TB] FAIL coll_replay_hit: got rvalid=%b data=%h want 1 beef", rvalid_o, rdata_o); end
        total++; if (rd_tag_o !== 44'hABC) begin bad++; $display("[TB] FAIL coll_held_tag: got %h want abc", rd_tag_o); end
        @(negedge clk_i); clear_inputs(); #1;
    endtask

    task automatic test_kill_miss();
        issue_req(8'h40, 4'h0, 2'd3, 1'b1);
        @(negedge clk_i); clear_inputs(); tag_valid_i = 1; tag_i = 44'h123; #1;
        @(negedge clk_i); clear_inputs(); miss_ack_i = 1; #1;
        @(negedge clk_i); clear_inputs(); kill_req_i = 1; #1;
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL kill_rvalid: got %b want 1", rvalid_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (rvalid_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL kill_wait: got rvalid=%b busy=%b want 0 1", rvalid_o, busy_o); end
        @(negedge clk_i); miss_rtrn_vld_i = 1; miss_rtrn_data_i = 64'hFFFF; #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL kill_no_second_rvalid: got %b want 0", rvalid_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL kill_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        issue_req(8'h20, 4'h0, 2'd3, 1'b1);
        @(negedge clk_i);
        clear_inputs(); tag_valid_i = 1; tag_i = 44'h100; rd_hit_oh_i = 4'b0001; rd_data_i = 64'h1111;
        req_valid_i = 1; req_idx_i = 8'h21; req_off_i = 4'h8; req_size_i = 2'd3; rd_ack_i = 1;
        #1;
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 64'h1111) begin bad++; $display("[TB] FAIL b2b_first: got rvalid=%b data=%h want 1 1111", rvalid_o, rdata_o); end
        total++; if (req_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_gnt: got %b want 1", req_gnt_o); end
        total++; if (rd_idx_o !== 8'h21) begin bad++; $display("[TB] FAIL b2b_second_idx: got %h want 21", rd_idx_o); end
        @(negedge clk_i);
        clear_inputs(); tag_valid_i = 1; tag_i = 44'h101; rd_hit_oh_i = 4'b0010; rd_data_i = 64'h2222;
        #1;
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 64'h2222) begin bad++; $display("[TB] FAIL b2b_second: got rvalid=%b data=%h want 1 2222", rvalid_o, rdata_o); end
        total++; if (rd_tag_o !== 44'h101) begin bad++; $display("[TB] FAIL b2b_fresh_tag: got %h want 101", rd_tag_o); end
        @(negedge clk_i); clear_inputs(); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_stall();
        @(negedge clk_i);
        clear_inputs(); cache_en_i = 1; stall_i = 1; req_valid_i = 1; req_idx_i = 8'h66; rd_ack_i = 1;
        #1;
        total++; if (rd_req_o !== 1'b0 || req_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_block: got rd_req=%b gnt=%b want 0 0", rd_req_o, req_gnt_o); end
        @(negedge clk_i); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_idle: got busy=%b want 0", busy_o); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_noncacheable();
        test_collision();
        test_kill_miss();
        test_back_to_back();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
